// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: datapath widths, reset PC,
// FSM state encoding and the redirect alignment helper.
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: entries are allocated with their PC on request, filled
// with the instruction word on response, and popped by decode.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   alloc,
   input  logic [XLEN-1:0]        alloc_pc,
   input  logic                   fill,
   input  logic [ILEN-1:0]        fill_data,
   input  logic                   pop,
   output logic                   full,
   output logic [$clog2(DEPTH):0] pending,
   output logic                   head_valid,
   output logic [XLEN-1:0]        head_pc,
   output logic [ILEN-1:0]        head_data
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [XLEN-1:0] pc_q   [DEPTH];
   logic [ILEN-1:0] data_q [DEPTH];
   logic [PW-1:0]   head, fill_ptr, tail;
   logic [CW-1:0]   count, unfilled;
   logic            head_filled, bypass;
   logic            alloc_ok, fill_ok, pop_ok;

   assign full        = (count == CW'(DEPTH));
   assign pending     = unfilled;
   assign head_filled = (count != unfilled);
   // With no filled entry, the oldest unfilled entry is the head, so a
   // response can be handed straight to decode in the cycle it arrives.
   assign bypass      = fill_ok && !head_filled;
   assign head_valid  = head_filled || bypass;
   assign head_pc     = pc_q[head];
   assign head_data   = bypass ? fill_data : data_q[head];

   assign alloc_ok = alloc && !full;
   assign fill_ok  = fill && (unfilled != '0);
   assign pop_ok   = pop && head_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            data_q[i] <= '0;
         end
         head     <= '0;
         fill_ptr <= '0;
         tail     <= '0;
         count    <= '0;
         unfilled <= '0;
      end else if (flush) begin
         head     <= '0;
         fill_ptr <= '0;
         tail     <= '0;
         count    <= '0;
         unfilled <= '0;
      end else begin
         if (alloc_ok) begin
            pc_q[tail] <= alloc_pc;
            tail       <= tail + 1'b1;
         end
         if (fill_ok) begin
            data_q[fill_ptr] <= fill_data;
            fill_ptr         <= fill_ptr + 1'b1;
         end
         if (pop_ok) begin
            head <= head + 1'b1;
         end
         count    <= count + CW'(alloc_ok) - CW'(pop_ok);
         unfilled <= unfilled + CW'(alloc_ok) - CW'(fill_ok);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, IDLE/FETCH/DRAIN control and redirect handling in
// front of fetch_buffer. Define IFETCH_MISALIGN_CHK_EN to add the misalign_err port.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   output logic [ILEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready
`ifdef IFETCH_MISALIGN_CHK_EN
   ,
   output logic            misalign_err
`endif
);

   localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_t    state, state_n;
   logic [XLEN-1:0] pc, pc_n, target;
   logic [CW-1:0]   stale, stale_n, pending;
   logic            full, req_fire, fill, pop;

   assign target        = align_pc(redirect_pc);
   assign imem_req_addr = pc;
   assign req_fire      = imem_req_valid && imem_req_ready;
   assign fill          = imem_rsp_valid && (state == FETCH) && !redirect_valid;
   assign pop           = inst_valid && inst_ready;

   fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .alloc     (req_fire),
      .alloc_pc  (pc),
      .fill      (fill),
      .fill_data (imem_rsp_data),
      .pop       (pop),
      .full      (full),
      .pending   (pending),
      .head_valid(inst_valid),
      .head_pc   (inst_pc),
      .head_data (inst_data)
   );

   always_comb begin
      state_n        = state;
      pc_n           = pc;
      stale_n        = stale;
      imem_req_valid = (state == FETCH) && !full && !redirect_valid;
      if (req_fire) begin
         pc_n = pc + PC_STEP;
      end
      if ((state == DRAIN) && imem_rsp_valid && (stale != '0)) begin
         stale_n = stale - 1'b1;
      end
      case (state)
         IDLE:    state_n = FETCH;
         FETCH:   state_n = FETCH;
         DRAIN:   if (stale_n == '0) state_n = FETCH;
         default: state_n = IDLE;
      endcase
      // Outside DRAIN every unfilled entry becomes stale; a response arriving
      // alongside the redirect is one of them and is consumed here.
      if (redirect_valid) begin
         pc_n = target;
         if (state != DRAIN) begin
            stale_n = stale + pending - CW'(imem_rsp_valid && (pending != '0));
         end
         state_n = (stale_n != '0) ? DRAIN : FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pc    <= RESET_PC;
         stale <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         stale <= stale_n;
      end
   end

`ifdef IFETCH_MISALIGN_CHK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a 1-cycle-latency
// instruction memory model whose word at address a is a ^ 32'hC0DE_0000.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_ready = 1'b0;
   logic        imem_req_valid, inst_valid;
   logic [31:0] imem_req_addr, inst_data, inst_pc;
`ifdef IFETCH_MISALIGN_CHK_EN
   logic        misalign_err;
`endif

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .imem_req_valid(imem_req_valid),
      .imem_req_addr (imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .inst_valid    (inst_valid),
      .inst_data     (inst_data),
      .inst_pc       (inst_pc),
      .inst_ready    (inst_ready)
`ifdef IFETCH_MISALIGN_CHK_EN
      ,
      .misalign_err  (misalign_err)
`endif
   );

   int checks = 0;
   int errors = 0;

   logic        drv_reset = 1'b1, drv_inst_ready = 1'b0, drv_redir = 1'b0;
   logic        drv_hold = 1'b0, drv_stray = 1'b0;
   logic [31:0] drv_rpc = '0;
   logic [31:0] q[$];

   logic        s_req_valid, s_req_fire, s_inst_valid, s_inst_fire, s_misalign;
   logic [31:0] s_req_addr, s_inst_pc, s_inst_data;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // One cycle: drive inputs at negedge, sample 1 ns later, log accepted requests.
   task automatic step();
      @(negedge clk);
      reset          = drv_reset;
      inst_ready     = drv_inst_ready;
      redirect_valid = drv_redir;
      redirect_pc    = drv_rpc;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (drv_reset) begin
         q.delete();
      end else if (drv_stray) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end else if (!drv_hold && q.size() != 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word_at(q.pop_front());
      end
      #1;
      s_req_valid  = imem_req_valid;
      s_req_addr   = imem_req_addr;
      s_req_fire   = imem_req_valid && imem_req_ready && !drv_reset;
      s_inst_valid = inst_valid;
      s_inst_fire  = inst_valid && inst_ready;
      s_inst_pc    = inst_pc;
      s_inst_data  = inst_data;
`ifdef IFETCH_MISALIGN_CHK_EN
      s_misalign   = misalign_err;
`else
      s_misalign   = 1'b0;
`endif
      if (s_req_fire) q.push_back(imem_req_addr);
   endtask

   task automatic do_reset();
      drv_reset = 1'b1; drv_redir = 1'b0; drv_hold = 1'b0; drv_stray = 1'b0;
      step();
      step();
      drv_reset = 1'b0;
   endtask

   task automatic test_reset();
      drv_inst_ready = 1'b1;
      do_reset();
      checks++;
      if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b0 || s_misalign !== 1'b0) begin
         errors++;
         $display("FAIL reset_valids got req=%b inst=%b mis=%b exp 0 0 0", s_req_valid, s_inst_valid, s_misalign);
      end
      checks++;
      if (s_inst_pc !== 32'h0 || s_inst_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got pc=%h data=%h exp 0 0", s_inst_pc, s_inst_data);
      end
   endtask

   task automatic test_stream();
      logic [31:0] e;
      drv_inst_ready = 1'b1;
      do_reset();
      step();
      checks++;
      if (s_req_valid !== 1'b0) begin
         errors++; $display("FAIL stream_idle got req_valid=%b exp 0", s_req_valid);
      end
      step();
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0 || s_inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_first_req got v=%b a=%h inst=%b exp 1 00000000 0", s_req_valid, s_req_addr, s_inst_valid);
      end
      for (int i = 2; i < 10; i++) begin
         step();
         e = 32'(4 * (i - 2));
         checks++;
         if (s_inst_fire !== 1'b1 || s_inst_pc !== e || s_inst_data !== word_at(e)) begin
            errors++;
            $display("FAIL stream_inst c%0d got v=%b pc=%h d=%h exp 1 %h %h", i, s_inst_fire, s_inst_pc, s_inst_data, e, word_at(e));
         end
         checks++;
         if (s_req_valid !== 1'b1 || s_req_addr !== e + 32'd4) begin
            errors++;
            $display("FAIL stream_req c%0d got v=%b a=%h exp 1 %h", i, s_req_valid, s_req_addr, e + 32'd4);
         end
      end
   endtask

   task automatic test_stall();
      int          fires;
      int          n;
      logic [31:0] e;
      drv_inst_ready = 1'b0;
      do_reset();
      fires = 0;
      for (int i = 0; i < 10; i++) begin
         drv_stray = (i == 6);
         step();
         if (s_req_fire) fires++;
      end
      drv_stray = 1'b0;
      checks++;
      if (fires != 2) begin
         errors++; $display("FAIL stall_req_count got %0d exp 2", fires);
      end
      checks++;
      if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b1 || s_inst_pc !== 32'h0) begin
         errors++;
         $display("FAIL stall_hold got req=%b inst=%b pc=%h exp 0 1 00000000", s_req_valid, s_inst_valid, s_inst_pc);
      end
      drv_inst_ready = 1'b1;
      e = '0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (s_inst_fire) begin
            checks++;
            if (s_inst_pc !== e || s_inst_data !== word_at(e)) begin
               errors++;
               $display("FAIL stall_resume got pc=%h d=%h exp %h %h", s_inst_pc, s_inst_data, e, word_at(e));
            end
            e = e + 32'd4;
            n++;
         end
      end
      checks++;
      if (n != 8) begin
         errors++; $display("FAIL stall_resume_count got %0d exp 8", n);
      end
   endtask

   task automatic test_redirect_drain();
      drv_inst_ready = 1'b1;
      do_reset();
      drv_hold = 1'b1;
      step(); step(); step();
      drv_redir = 1'b1; drv_rpc = 32'h0000_0100;
      step();
      checks++;
      if (s_req_valid !== 1'b0 || q.size() != 2) begin
         errors++; $display("FAIL drain_setup got req=%b outstanding=%0d exp 0 2", s_req_valid, q.size());
      end
      drv_redir = 1'b0; drv_hold = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b0) begin
            errors++; $display("FAIL drain_discard r%0d got req=%b inst=%b exp 0 0", i, s_req_valid, s_inst_valid);
         end
      end
      step();
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
         errors++; $display("FAIL drain_refetch got v=%b a=%h exp 1 00000100", s_req_valid, s_req_addr);
      end
      step();
      checks++;
      if (s_inst_fire !== 1'b1 || s_inst_pc !== 32'h100 || s_inst_data !== word_at(32'h100)) begin
         errors++;
         $display("FAIL drain_target got v=%b pc=%h d=%h exp 1 00000100 %h", s_inst_fire, s_inst_pc, s_inst_data, word_at(32'h100));
      end
   endtask

   task automatic test_redirect_collide();
      drv_inst_ready = 1'b0;
      do_reset();
      step(); step(); step();
      drv_inst_ready = 1'b1; drv_redir = 1'b1; drv_rpc = 32'h0000_0200;
      step();
      checks++;
      if (s_inst_fire !== 1'b1 || s_inst_pc !== 32'h0 || s_inst_data !== word_at(32'h0) || imem_rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL collide_handshake got v=%b pc=%h d=%h rsp=%b exp 1 00000000 %h 1", s_inst_fire, s_inst_pc, s_inst_data, imem_rsp_valid, word_at(32'h0));
      end
      drv_redir = 1'b0;
      step();
      checks++;
      if (s_inst_valid !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h200) begin
         errors++;
         $display("FAIL collide_flush got inst=%b req=%b a=%h exp 0 1 00000200", s_inst_valid, s_req_valid, s_req_addr);
      end
      step();
      checks++;
      if (s_inst_fire !== 1'b1 || s_inst_pc !== 32'h200 || s_inst_data !== word_at(32'h200)) begin
         errors++;
         $display("FAIL collide_target got v=%b pc=%h d=%h exp 1 00000200 %h", s_inst_fire, s_inst_pc, s_inst_data, word_at(32'h200));
      end
   endtask

   task automatic test_wrap();
      drv_inst_ready = 1'b1;
      do_reset();
      drv_redir = 1'b1; drv_rpc = 32'hFFFF_FFFC;
      step();
      drv_redir = 1'b0;
      step();
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_top got v=%b a=%h exp 1 fffffffc", s_req_valid, s_req_addr);
      end
      step();
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0 || s_inst_pc !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_zero got v=%b a=%h ipc=%h exp 1 00000000 fffffffc", s_req_valid, s_req_addr, s_inst_pc);
      end
      step();
      checks++;
      if (s_inst_fire !== 1'b1 || s_inst_pc !== 32'h0 || s_inst_data !== word_at(32'h0)) begin
         errors++; $display("FAIL wrap_inst got v=%b pc=%h d=%h exp 1 00000000 %h", s_inst_fire, s_inst_pc, s_inst_data, word_at(32'h0));
      end
   endtask

   task automatic test_misalign();
      drv_inst_ready = 1'b1;
      do_reset();
      drv_redir = 1'b1; drv_rpc = 32'h0000_0102;
      step();
      checks++;
      if (s_misalign !== 1'b0) begin
         errors++; $display("FAIL misalign_pre got %b exp 0", s_misalign);
      end
      drv_redir = 1'b0;
      step();
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
         errors++; $display("FAIL misalign_addr got v=%b a=%h exp 1 00000100", s_req_valid, s_req_addr);
      end
`ifdef IFETCH_MISALIGN_CHK_EN
      checks++;
      if (s_misalign !== 1'b1) begin
         errors++; $display("FAIL misalign_pulse got %b exp 1", s_misalign);
      end
`endif
      step();
      checks++;
      if (s_misalign !== 1'b0 || s_inst_fire !== 1'b1 || s_inst_pc !== 32'h100) begin
         errors++; $display("FAIL misalign_after got mis=%b v=%b pc=%h exp 0 1 00000100", s_misalign, s_inst_fire, s_inst_pc);
      end
   endtask

   task automatic test_reset_mid();
      drv_inst_ready = 1'b1;
      do_reset();
      step(); step(); step(); step();
      do_reset();
      checks++;
      if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b0 || s_inst_pc !== 32'h0 || s_inst_data !== 32'h0) begin
         errors++;
         $display("FAIL midreset_state got req=%b inst=%b pc=%h d=%h exp 0 0 0 0", s_req_valid, s_inst_valid, s_inst_pc, s_inst_data);
      end
      step(); step();
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0) begin
         errors++; $display("FAIL midreset_req got v=%b a=%h exp 1 00000000", s_req_valid, s_req_addr);
      end
      step();
      checks++;
      if (s_inst_fire !== 1'b1 || s_inst_pc !== 32'h0 || s_inst_data !== word_at(32'h0)) begin
         errors++; $display("FAIL midreset_inst got v=%b pc=%h d=%h exp 1 00000000 %h", s_inst_fire, s_inst_pc, s_inst_data, word_at(32'h0));
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drain();
      test_redirect_collide();
      test_wrap();
      test_misalign();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
